pn_expr_tx: RTL and testbench
=============================

Name: pn_expr_tx

Overview:
Transmitter side of the PN evaluator token interface. A host loads one expression into a local token buffer and requests a send. The block then drives the evaluator's in_valid/in/mode/operator burst, waits for the single-cycle out_valid/out reply, and returns the signed result to the host. It also flags protocol violations: length, reply width, timeout, and nonzero out while out_valid is low.

Parameters:
DEPTH, 15, token buffer entries; max tokens per expression, which is 2*num+1 with num<=7
TOK_W, 3, width of token value "in"
RES_W, 64, width of signed result
TIMEOUT, 1000, max cycles allowed from end of burst to out_valid
GAP, 2, minimum idle cycles between result capture and next burst

Ports:
clk  input  1  single system clock
rst  input  1  asynchronous, active-high reset
wr_valid  input  1  host token write strobe
wr_ready  output  1  buffer can accept a token this cycle
wr_in  input  TOK_W  token value
wr_operator  input  1  token is an operator (1) or operand (0)
start  input  1  one-cycle send request
start_mode  input  1  mode bit for this expression
busy  output  1  high in every state except IDLE
in_valid  output  1  burst valid to evaluator
in  output  TOK_W  token value to evaluator
mode  output  1  mode to evaluator, valid on first burst cycle only
operator  output  1  operator flag to evaluator
out_valid  input  1  evaluator result valid
out  input  RES_W  evaluator result, signed
res_valid  output  1  one-cycle result strobe to host
res_data  output  RES_W  captured signed result, held until next capture
err  output  3  sticky flags {timeout, proto, len}; cleared on accepted start

Behaviour:
- Reset: all outputs 0, token count 0, state IDLE. Reset mid-burst drops in_valid on the reset edge with no partial continuation, and the buffer is emptied.
- FSM states: IDLE -> SEND -> WAIT -> GAPW -> IDLE.
- IDLE:
  - wr_ready = !full && !start. A write with wr_valid && wr_ready appends {wr_in, wr_operator} and increments count.
  - start with count odd and >=1: latch start_mode, clear err, go to SEND.
  - start with count even or 0: set err[0] (len), stay IDLE, keep buffer contents.
  - A write while full is dropped; wr_ready is already low.
- SEND:
  - Lasts exactly count cycles. Burst is contiguous with no bubbles.
  - Timing: start sampled at edge t; in_valid is high for cycles t+1 .. t+count.
  - Cycle k drives buffer entry k on in/operator.
  - mode = latched mode on k=0, 0 on all later burst cycles.
  - When in_valid=0, in/mode/operator are all driven 0.
- WAIT:
  - Counter starts at 0 on the first cycle after the burst.
  - out_valid=1: capture out into res_data, pulse res_valid for exactly 1 cycle (the cycle after capture), go to GAPW.
  - Counter exceeds TIMEOUT: set err[2], go to GAPW with no res_valid.
- GAPW:
  - Waits GAP cycles, then goes to IDLE with count cleared.
  - out_valid high in the cycle after capture (pulse wider than 1 cycle) sets err[1].
- Monitor, all states: out_valid=0 with out!=0 sets err[1].
- start outside IDLE is ignored. busy=1 in SEND/WAIT/GAPW.
- No arithmetic beyond counters:
  - token counter width = clog2(DEPTH+1)
  - wait counter width = clog2(TIMEOUT+2)
  - res_data is passed through unmodified, sign preserved.

Decomposition:
- Shared package pn_pkg holds:
  - TOK_W and RES_W constants
  - the token struct {val[TOK_W-1:0], is_op}
  - the FSM state enum
  - the err bit index constants
- One sub-module, pn_tok_buf: a DEPTH-entry write-pointer/read-pointer register array with count, full, and rewind. The buffer is read sequentially in SEND and cleared on return to IDLE.

Test Plan:
- Load (3,0),(4,0),(0,1); start, start_mode=1 -> in_valid high 3 consecutive cycles with in=3,4,0, operator=0,0,1, mode=1,0,0. Model replies out=7 after 5 cycles -> res_valid 1 cycle, res_data=7, err=0.
- Load 15 tokens -> wr_ready=0 afterwards, 16th write dropped. Start -> 15-cycle burst; model reply out=-9223372036854775808 -> res_data=64'h8000_0000_0000_0000.
- Load 2 tokens; start -> err=3'b001, in_valid stays 0, busy stays 0, count remains 2.
- Send 1 token, model never asserts out_valid -> err=3'b100 after 1001 WAIT cycles, no res_valid, back to IDLE after GAP cycles.
- Model holds out_valid 2 cycles -> err[1]=1, res_data holds the first value. Separately, out=5 with out_valid=0 -> err[1]=1.
- Assert rst during cycle 2 of a 5-token burst -> in_valid=0 immediately, buffer empty. Post-reset 3-token send completes correctly.

Source files
------------

// File: rtl/pn_pkg.sv
// Shared types and constants for the PN evaluator token transmitter.
package pn_pkg;

  localparam int TOK_W = 3;
  localparam int RES_W = 64;

  // One buffered token: value plus operator/operand flag.
  typedef struct packed {
    logic [TOK_W-1:0] val;
    logic             is_op;
  } tok_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    GAPW
  } state_t;

  // Bit positions inside the sticky err vector.
  localparam int ERR_LEN   = 0;
  localparam int ERR_PROTO = 1;
  localparam int ERR_TMO   = 2;

endpackage

// File: rtl/pn_expr_tx_if.sv
// Host and evaluator signals of the token transmitter, grouped as one bundle.
interface pn_expr_tx_if;
  import pn_pkg::*;

  // host token load / send request
  logic             wr_valid;
  logic             wr_ready;
  logic [TOK_W-1:0] wr_in;
  logic             wr_operator;
  logic             start;
  logic             start_mode;
  logic             busy;
  // evaluator burst
  logic             in_valid;
  logic [TOK_W-1:0] in;
  logic             mode;
  logic             operator;
  // evaluator reply and host result
  logic             out_valid;
  logic [RES_W-1:0] out;
  logic             res_valid;
  logic [RES_W-1:0] res_data;
  logic [2:0]       err;

  modport master (
    input  wr_valid, wr_in, wr_operator, start, start_mode, out_valid, out,
    output wr_ready, busy, in_valid, in, mode, operator, res_valid, res_data, err
  );

  modport slave (
    output wr_valid, wr_in, wr_operator, start, start_mode, out_valid, out,
    input  wr_ready, busy, in_valid, in, mode, operator, res_valid, res_data, err
  );

endinterface

// File: rtl/pn_tok_buf.sv
// Token buffer: sequential write pointer (= count), sequential read pointer,
// rewind of the read side and full clear.
module pn_tok_buf
  import pn_pkg::*;
#(
  parameter int DEPTH = 15,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  tok_t             wr_tok,
  input  logic             rd_en,
  input  logic             rewind,
  input  logic             clear,
  output tok_t             rd_tok,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             rd_done
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  tok_t             mem [DEPTH];
  logic [CNT_W-1:0] rd_ptr;

  assign full    = (count == CNT_W'(DEPTH));
  assign rd_done = (rd_ptr == count);
  assign rd_tok  = (rd_ptr < CNT_W'(DEPTH)) ? mem[rd_ptr[IDX_W-1:0]] : '0;

  // Pointer/count bookkeeping; clear empties the buffer on return to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      count  <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)
        count <= count + CNT_W'(1);
      if (rewind)
        rd_ptr <= '0;
      else if (rd_en && !rd_done)
        rd_ptr <= rd_ptr + CNT_W'(1);
    end
  end

  // Token storage, written at the current count position.
  always_ff @(posedge clk) begin
    if (wr_en && !full)
      mem[count[IDX_W-1:0]] <= wr_tok;
  end

endmodule

// File: rtl/pn_expr_tx.sv
// PN evaluator transmitter: buffers one expression, bursts it to the
// evaluator, waits for the single-cycle reply and reports it to the host.
module pn_expr_tx
  import pn_pkg::*;
#(
  parameter int DEPTH   = 15,
  parameter int TIMEOUT = 1000,
  parameter int GAP     = 2
) (
  input logic          clk,
  input logic          rst,
  pn_expr_tx_if.master bus
);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WCNT_W = $clog2(TIMEOUT + 2);
  localparam int GCNT_W = (GAP > 1) ? $clog2(GAP) : 1;

  state_t            state;
  logic [WCNT_W-1:0] wait_cnt;
  logic [WCNT_W-1:0] wait_nxt;
  logic [GCNT_W-1:0] gap_cnt;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              rd_done;
  tok_t              rd_tok;
  tok_t              wr_tok;
  logic              wr_ready_w;
  logic              buf_wr;
  logic              buf_rd;
  logic              buf_rewind;
  logic              gap_end;
  logic              start_ok;
  logic              start_bad;
  logic              wait_tmo;

  logic              in_valid_q;
  logic [TOK_W-1:0]  in_q;
  logic              mode_q;
  logic              operator_q;
  logic              res_valid_q;
  logic [RES_W-1:0]  res_data_q;
  logic [2:0]        err_q;
  logic [2:0]        err_nxt;

  assign wr_tok     = {bus.wr_in, bus.wr_operator};
  assign wr_ready_w = (state == IDLE) && !full && !bus.start;
  assign buf_wr     = bus.wr_valid && wr_ready_w;
  assign start_ok   = (state == IDLE) && bus.start && (count != '0) && count[0];
  assign start_bad  = (state == IDLE) && bus.start && !((count != '0) && count[0]);
  // Entry 0 is consumed on the start edge, the rest one per SEND cycle.
  assign buf_rd     = start_ok || ((state == SEND) && !rd_done);
  assign buf_rewind = (state == SEND) && rd_done;
  assign gap_end    = (state == GAPW) && (gap_cnt == GCNT_W'(GAP - 1));
  assign wait_nxt   = wait_cnt + WCNT_W'(1);
  assign wait_tmo   = (state == WAIT) && !bus.out_valid && (wait_nxt > WCNT_W'(TIMEOUT));

  assign bus.wr_ready  = wr_ready_w;
  assign bus.busy      = (state != IDLE);
  assign bus.in_valid  = in_valid_q;
  assign bus.in        = in_q;
  assign bus.mode      = mode_q;
  assign bus.operator  = operator_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.err       = err_q;

  pn_tok_buf #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (buf_wr),
    .wr_tok  (wr_tok),
    .rd_en   (buf_rd),
    .rewind  (buf_rewind),
    .clear   (gap_end),
    .rd_tok  (rd_tok),
    .count   (count),
    .full    (full),
    .rd_done (rd_done)
  );

  // Sticky error flags: cleared by an accepted start, then OR in new events.
  always_comb begin
    err_nxt = start_ok ? 3'b000 : err_q;
    if (start_bad)
      err_nxt[ERR_LEN] = 1'b1;
    if (wait_tmo)
      err_nxt[ERR_TMO] = 1'b1;
    if ((state == GAPW) && bus.out_valid && res_valid_q)
      err_nxt[ERR_PROTO] = 1'b1;
    if (!bus.out_valid && (bus.out != '0))
      err_nxt[ERR_PROTO] = 1'b1;
  end

  // Main sequencer with registered burst/result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
      in_valid_q  <= 1'b0;
      in_q        <= '0;
      mode_q      <= 1'b0;
      operator_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      err_q       <= '0;
    end else begin
      res_valid_q <= 1'b0;
      err_q       <= err_nxt;
      case (state)
        IDLE: begin
          if (start_ok) begin
            in_valid_q <= 1'b1;
            in_q       <= rd_tok.val;
            operator_q <= rd_tok.is_op;
            mode_q     <= bus.start_mode;
            state      <= SEND;
          end
        end
        SEND: begin
          mode_q <= 1'b0;
          if (rd_done) begin
            in_valid_q <= 1'b0;
            in_q       <= '0;
            operator_q <= 1'b0;
            wait_cnt   <= '0;
            state      <= WAIT;
          end else begin
            in_q       <= rd_tok.val;
            operator_q <= rd_tok.is_op;
          end
        end
        WAIT: begin
          if (bus.out_valid) begin
            res_data_q  <= bus.out;
            res_valid_q <= 1'b1;
            gap_cnt     <= '0;
            state       <= GAPW;
          end else if (wait_tmo) begin
            gap_cnt <= '0;
            state   <= GAPW;
          end else begin
            wait_cnt <= wait_nxt;
          end
        end
        GAPW: begin
          if (gap_end)
            state <= IDLE;
          else
            gap_cnt <= gap_cnt + GCNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pn_expr_tx.sv
// Self-checking bench for pn_expr_tx: directed table, hand sequences and
// randomized expressions against a queue-based model of the buffer.
module tb_pn_expr_tx;
  import pn_pkg::*;

  localparam int DEPTH   = 15;
  localparam int TIMEOUT = 1000;
  localparam int GAP     = 2;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  tok_t        mq[$];
  logic [63:0] last_res;

  pn_expr_tx_if bus ();

  pn_expr_tx #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .GAP     (GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1);
  end

  typedef struct {
    int          n;
    bit          m;
    int          dly;
    logic [63:0] val;
    int          width;
    logic [2:0]  exp_err;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic tok_t mk(input int v, input int o);
    tok_t t;
    t.val   = TOK_W'(v);
    t.is_op = 1'(o);
    return t;
  endfunction

  task automatic load_tok(input tok_t t);
    bus.wr_valid    = 1'b1;
    bus.wr_in       = t.val;
    bus.wr_operator = t.is_op;
    #1;
    chk("wr_ready", 64'(bus.wr_ready), 64'(mq.size() < DEPTH));
    if (mq.size() < DEPTH)
      mq.push_back(t);
    step();
    bus.wr_valid    = 1'b0;
    bus.wr_in       = '0;
    bus.wr_operator = 1'b0;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++)
      load_tok(mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 1))));
  endtask

  // width: 0 = no reply, 1 = single-cycle reply, 2 = reply held two cycles
  task automatic send(input bit m, input int dly, input logic [63:0] val,
                      input int width, input logic [2:0] exp_err);
    int len;
    bus.start      = 1'b1;
    bus.start_mode = m;
    #1;
    chk("wr_ready_start", 64'(bus.wr_ready), 64'(0));
    step();
    bus.start      = 1'b0;
    bus.start_mode = 1'b0;
    if (mq.size() % 2 == 0) begin
      chk("len_err", 64'(bus.err), 64'(3'b001));
      chk("len_busy", 64'(bus.busy), 64'(0));
      chk("len_in_valid", 64'(bus.in_valid), 64'(0));
      return;
    end
    chk("err_cleared", 64'(bus.err), 64'(0));
    chk("busy_send", 64'(bus.busy), 64'(1));
    len = 0;
    while (bus.in_valid === 1'b1 && len < 40) begin
      if (len < mq.size()) begin
        chk("burst_in", 64'(bus.in), 64'(mq[len].val));
        chk("burst_op", 64'(bus.operator), 64'(mq[len].is_op));
        chk("burst_mode", 64'(bus.mode), 64'((len == 0) ? m : 1'b0));
      end
      len++;
      step();
    end
    chk("burst_len", 64'(len), 64'(mq.size()));
    chk("post_burst_zero", 64'({bus.in, bus.mode, bus.operator}), 64'(0));
    if (width == 0) begin
      repeat (TIMEOUT) step();
      chk("tmo_early", 64'(bus.err), 64'(0));
      chk("tmo_wait_busy", 64'(bus.busy), 64'(1));
      step();
      chk("tmo_err", 64'(bus.err), 64'(3'b100));
      chk("tmo_no_res", 64'(bus.res_valid), 64'(0));
      chk("tmo_res_hold", bus.res_data, last_res);
    end else begin
      repeat (dly) step();
      bus.out_valid = 1'b1;
      bus.out       = val;
      step();
      if (width == 1) begin
        bus.out_valid = 1'b0;
        bus.out       = '0;
      end else begin
        bus.out = val ^ 64'h1;
      end
      chk("res_valid", 64'(bus.res_valid), 64'(1));
      chk("res_data", bus.res_data, val);
      last_res = val;
    end
    step();
    bus.out_valid = 1'b0;
    bus.out       = '0;
    chk("res_pulse_end", 64'(bus.res_valid), 64'(0));
    chk("gap_busy", 64'(bus.busy), 64'(1));
    chk("res_data_hold", bus.res_data, last_res);
    step();
    chk("idle_busy", 64'(bus.busy), 64'(0));
    chk("err_final", 64'(bus.err), 64'(exp_err));
    mq.delete();
  endtask

  initial begin
    errors          = 0;
    checks          = 0;
    last_res        = '0;
    rst             = 1'b1;
    bus.wr_valid    = 1'b0;
    bus.wr_in       = '0;
    bus.wr_operator = 1'b0;
    bus.start       = 1'b0;
    bus.start_mode  = 1'b0;
    bus.out_valid   = 1'b0;
    bus.out         = '0;

    tbl[0] = '{1,  1'b0, 0,    64'd1,                  1, 3'b000};
    tbl[1] = '{15, 1'b1, 1000, 64'hffff_ffff_ffff_fffe, 1, 3'b000};
    tbl[2] = '{7,  1'b0, 3,    64'h7fff_ffff_ffff_ffff, 1, 3'b000};
    tbl[3] = '{5,  1'b1, 2,    64'd42,                 2, 3'b010};
    tbl[4] = '{1,  1'b1, 0,    64'd0,                  0, 3'b100};
    tbl[5] = '{9,  1'b0, 10,   64'hffff_ffff_ffff_fff7, 1, 3'b000};

    // reset state
    step();
    step();
    chk("rst_in_valid", 64'(bus.in_valid), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_res_valid", 64'(bus.res_valid), 64'(0));
    chk("rst_res_data", bus.res_data, 64'(0));
    chk("rst_err", 64'(bus.err), 64'(0));
    chk("rst_in_bus", 64'({bus.in, bus.mode, bus.operator}), 64'(0));
    rst = 1'b0;
    step();
    chk("rst_wr_ready", 64'(bus.wr_ready), 64'(1));

    // basic expression 3 4 +
    load_tok(mk(3, 0));
    load_tok(mk(4, 0));
    load_tok(mk(0, 1));
    send(1'b1, 5, 64'd7, 1, 3'b000);

    // full buffer, extra write dropped, most negative result
    load(16);
    #1;
    chk("full_ready", 64'(bus.wr_ready), 64'(0));
    send(1'b0, 4, 64'h8000_0000_0000_0000, 1, 3'b000);

    // even length rejected, buffer kept, then completed to odd and sent
    load(2);
    send(1'b1, 0, 64'd0, 1, 3'b001);
    step();
    chk("len_stay_busy", 64'(bus.busy), 64'(0));
    chk("len_stay_in_valid", 64'(bus.in_valid), 64'(0));
    load(1);
    send(1'b1, 2, 64'd99, 1, 3'b000);

    // nonzero out while out_valid low
    bus.out = 64'd5;
    step();
    bus.out = '0;
    chk("proto_idle", 64'(bus.err), 64'(3'b010));
    step();
    chk("proto_sticky", 64'(bus.err), 64'(3'b010));

    // table-driven transactions
    for (int i = 0; i < 6; i++) begin
      load(tbl[i].n);
      send(tbl[i].m, tbl[i].dly, tbl[i].val, tbl[i].width, tbl[i].exp_err);
    end

    // reset during the second burst cycle
    load(5);
    bus.start      = 1'b1;
    bus.start_mode = 1'b1;
    step();
    bus.start      = 1'b0;
    bus.start_mode = 1'b0;
    step();
    chk("mid_in_valid", 64'(bus.in_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_in_valid", 64'(bus.in_valid), 64'(0));
    chk("mid_rst_busy", 64'(bus.busy), 64'(0));
    chk("mid_rst_res_data", bus.res_data, 64'(0));
    mq.delete();
    last_res = '0;
    step();
    rst = 1'b0;
    step();
    load(3);
    send(1'b0, 1, 64'd123, 1, 3'b000);

    // randomized odd-length expressions
    for (int r = 0; r < 8; r++) begin
      load(2 * int'($urandom_range(0, 7)) + 1);
      send(1'($urandom_range(0, 1)), int'($urandom_range(0, 40)),
           {$urandom, $urandom}, 1, 3'b000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
